// File: rtl/core_pkg.sv
// Shared definitions for the memory stage of the RV64 pipeline.
//   XLEN            : datapath width
//   SZ_*            : access size encodings held in funct3[1:0]
//   mem_state_e     : memory-access FSM states
//   ex_mem_t        : contents of the EX/MEM pipeline register
//   size_mask()     : byte-enable pattern of an access size at lane 0
//   is_misaligned() : address not a multiple of the access size
package core_pkg;

   localparam int unsigned XLEN = 64;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   typedef enum logic {
      RUN  = 1'b0,
      WAIT = 1'b1
   } mem_state_e;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] alu_result;
      logic            zero;
      logic [XLEN-1:0] target;
      logic [XLEN-1:0] store_data;
      logic [31:0]     instruction;
      logic            branch;
      logic            mem_read;
      logic            mem_write;
      logic            reg_write;
      logic            mem_to_reg;
   } ex_mem_t;

   function automatic logic [7:0] size_mask(input logic [1:0] sz);
      logic [7:0] m;
      case (sz)
         SZ_B:    m = 8'h01;
         SZ_H:    m = 8'h03;
         SZ_W:    m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] off);
      logic r;
      case (sz)
         SZ_B:    r = 1'b0;
         SZ_H:    r = off[0];
         SZ_W:    r = |off[1:0];
         default: r = |off;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: selects the addressed lane of a 64-bit load word, moves it to
// bit 0 and extends it to XLEN.
//   rdata   in  64  raw doubleword from data memory
//   addr_lo in  3   byte offset within the doubleword
//   funct3  in  3   [1:0] access size, [2] 1 = zero-extend
//   value   out 64  extended load value
module load_align
   import core_pkg::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [2:0]      addr_lo,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] value
);

   logic [XLEN-1:0] lane;

   always_comb begin
      lane  = rdata >> {addr_lo, 3'b000};
      value = lane;
      case (funct3[1:0])
         SZ_B:    value = funct3[2] ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
         SZ_H:    value = funct3[2] ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
         SZ_W:    value = funct3[2] ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
         default: value = lane;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM register, data-memory access with a variable-latency
// ready handshake, branch resolution and the MEM/WB register.
//   clk, reset             : clock, asynchronous active-high reset
//   ex_*                   : Execute-stage results and control bits
//   dmem_*                 : data-memory request/response port
//   stall, flush, pc_src   : pipeline control to earlier stages
//   branch_target          : registered branch target
//   EX_MEM_*, MEM_WB_*     : values seen by forwarding and writeback
//   bus_error              : sticky access-timeout flag
//   misaligned             : pulses while a misaligned access sits in MEM
//   stall_cycles           : saturating count of stalled cycles
module mem_stage
   import core_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ex_valid,
   input  logic [XLEN-1:0]  ex_alu_result,
   input  logic             ex_zero,
   input  logic [XLEN-1:0]  ex_target,
   input  logic [XLEN-1:0]  ex_store_data,
   input  logic [31:0]      ex_instruction,
   input  logic             ex_branch,
   input  logic             ex_mem_read,
   input  logic             ex_mem_write,
   input  logic             ex_reg_write,
   input  logic             ex_mem_to_reg,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [XLEN-1:0]  dmem_addr,
   output logic [XLEN-1:0]  dmem_wdata,
   output logic [7:0]       dmem_be,
   input  logic             dmem_ready,
   input  logic [XLEN-1:0]  dmem_rdata,
   output logic             stall,
   output logic             pc_src,
   output logic [XLEN-1:0]  branch_target,
   output logic             flush,
   output logic [XLEN-1:0]  EX_MEM_ALU_result,
   output logic [31:0]      EX_MEM_Instruction,
   output logic             EX_MEM_RegWrite,
   output logic [31:0]      MEM_WB_Instruction,
   output logic             MEM_WB_RegWrite,
   output logic [XLEN-1:0]  MEM_WB_WriteBack,
   output logic             bus_error,
   output logic             misaligned,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

   ex_mem_t         ex_mem_q, ex_mem_d;
   mem_state_e      state_q, state_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            bus_error_q, bus_error_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [31:0]     wb_instr_q, wb_instr_d;
   logic            wb_rw_q, wb_rw_d;
   logic [XLEN-1:0] wb_data_q, wb_data_d;

   logic [2:0]      funct3;
   logic [2:0]      addr_lo;
   logic            is_mem, memop, timeout;
   logic [XLEN-1:0] load_value;

   load_align u_load_align (
      .rdata   (dmem_rdata),
      .addr_lo (addr_lo),
      .funct3  (funct3),
      .value   (load_value)
   );

   always_comb begin
      funct3     = ex_mem_q.instruction[14:12];
      addr_lo    = ex_mem_q.alu_result[2:0];
      is_mem     = ex_mem_q.valid & (ex_mem_q.mem_read | ex_mem_q.mem_write);
      misaligned = is_mem & is_misaligned(funct3[1:0], addr_lo);
      memop      = is_mem & ~misaligned;
      // The cycle on which the WAIT counter has seen TIMEOUT-1 earlier wait
      // cycles is the TIMEOUT-th; the request is dropped there, so the
      // total stall of an abandoned access is exactly TIMEOUT cycles.
      timeout    = (state_q == WAIT) & ~dmem_ready & (to_cnt_q == TO_W'(TIMEOUT - 1));
      dmem_req   = memop & ~timeout;
      stall      = dmem_req & ~dmem_ready;
      flush      = ex_mem_q.valid & ex_mem_q.branch & ex_mem_q.zero;
      pc_src     = flush;
      dmem_we    = dmem_req & ex_mem_q.mem_write;
      dmem_addr  = {ex_mem_q.alu_result[XLEN-1:3], 3'b000};
      dmem_be    = memop ? (size_mask(funct3[1:0]) << addr_lo) : '0;
      dmem_wdata = (memop & ex_mem_q.mem_write) ? (ex_mem_q.store_data << {addr_lo, 3'b000}) : '0;
   end

   always_comb begin
      state_d  = state_q;
      to_cnt_d = to_cnt_q;
      case (state_q)
         RUN: begin
            if (stall) begin
               state_d  = WAIT;
               to_cnt_d = '0;
            end
         end
         default: begin
            if (dmem_ready || timeout || !memop) state_d = RUN;
            else                                 to_cnt_d = to_cnt_q + 1'b1;
         end
      endcase
   end

   always_comb begin
      bus_error_d = bus_error_q | timeout;
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;

      ex_mem_d = ex_mem_q;
      if (!stall) begin
         if (flush) begin
            ex_mem_d = '0;
         end else begin
            ex_mem_d.valid       = ex_valid;
            ex_mem_d.alu_result  = ex_alu_result;
            ex_mem_d.zero        = ex_zero;
            ex_mem_d.target      = ex_target;
            ex_mem_d.store_data  = ex_store_data;
            ex_mem_d.instruction = ex_instruction;
            ex_mem_d.branch      = ex_branch;
            ex_mem_d.mem_read    = ex_mem_read;
            ex_mem_d.mem_write   = ex_mem_write;
            ex_mem_d.reg_write   = ex_reg_write;
            ex_mem_d.mem_to_reg  = ex_mem_to_reg;
         end
      end

      wb_instr_d = '0;
      wb_rw_d    = 1'b0;
      wb_data_d  = '0;
      if (!stall) begin
         wb_instr_d = ex_mem_q.instruction;
         wb_rw_d    = ex_mem_q.reg_write & ex_mem_q.valid & ~misaligned;
         if (ex_mem_q.mem_to_reg) wb_data_d = timeout ? '0 : load_value;
         else                     wb_data_d = ex_mem_q.alu_result;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_mem_q    <= '0;
         state_q     <= RUN;
         to_cnt_q    <= '0;
         bus_error_q <= 1'b0;
         stall_cnt_q <= '0;
         wb_instr_q  <= '0;
         wb_rw_q     <= 1'b0;
         wb_data_q   <= '0;
      end else begin
         ex_mem_q    <= ex_mem_d;
         state_q     <= state_d;
         to_cnt_q    <= to_cnt_d;
         bus_error_q <= bus_error_d;
         stall_cnt_q <= stall_cnt_d;
         wb_instr_q  <= wb_instr_d;
         wb_rw_q     <= wb_rw_d;
         wb_data_q   <= wb_data_d;
      end
   end

   assign branch_target      = ex_mem_q.target;
   assign EX_MEM_ALU_result  = ex_mem_q.alu_result;
   assign EX_MEM_Instruction = ex_mem_q.instruction;
   assign EX_MEM_RegWrite    = ex_mem_q.reg_write & ex_mem_q.valid;
   assign MEM_WB_Instruction = wb_instr_q;
   assign MEM_WB_RegWrite    = wb_rw_q;
   assign MEM_WB_WriteBack   = wb_data_q;
   assign bus_error          = bus_error_q;
   assign stall_cycles       = stall_cnt_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- EX/MEM pipeline register, data-memory access stage and MEM/WB pipeline register for the 5-stage RV64 core.
- Consumes Execute outputs (ALU_result, Zero, Target) together with the store operand and control bits.
- Resolves branches and performs loads and stores over a variable-latency ready handshake, stalling upstream while waiting.
- Drives the EX_MEM_* and MEM_WB_* signals used by the forwarding unit and by writeback.

Parameters:
TIMEOUT, 255, maximum WAIT cycles before a memory access is aborted with bus_error.
CNT_W, 32, width of the stall-cycle performance counter.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
ex_valid  in  1  EX holds a real instruction
ex_alu_result  in  64  ALU result / effective address
ex_zero  in  1  ALU zero flag
ex_target  in  64  branch target
ex_store_data  in  64  forwarded rs2 value
ex_instruction  in  32  instruction word
ex_branch, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  in  1 each  control bits
dmem_req  out  1  access request
dmem_we  out  1  1 = store
dmem_addr  out  64  EX_MEM_ALU_result with [2:0] forced to 0
dmem_wdata  out  64  lane-shifted store data
dmem_be  out  8  byte enables
dmem_ready  in  1  access complete this cycle
dmem_rdata  in  64  load data, valid when dmem_ready is high
stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
pc_src  out  1  take branch
branch_target  out  64  registered Target
flush  out  1  squash IF/ID and ID/EX
EX_MEM_ALU_result  out  64
EX_MEM_Instruction  out  32
EX_MEM_RegWrite  out  1  gated by EX/MEM valid
MEM_WB_Instruction  out  32
MEM_WB_RegWrite  out  1
MEM_WB_WriteBack  out  64  writeback value
bus_error  out  1  sticky timeout flag
misaligned  out  1  one-cycle pulse
stall_cycles  out  CNT_W  stall counter

Behaviour:
- Reset (asynchronous, active-high): every register and output is 0, state is RUN, counter is 0, bus_error is 0.
- EX/MEM capture:
  - stall=1: EX/MEM holds its contents.
  - stall=0 and flush=1: EX/MEM loads a bubble (valid=0).
  - Otherwise EX/MEM loads the ex_* inputs.
- Branch resolution: pc_src = flush = EX/MEM valid & branch & zero, combinational from the registered values, so the branch penalty is 3 cycles.
- Memory operation: memop = EX/MEM valid & (mem_read | mem_write) & !misaligned_cond.
- Size and alignment:
  - Access size comes from funct3 = instruction[14:12], low two bits: 00 B, 01 H, 10 W, 11 D.
  - misaligned_cond = address not a multiple of the access size.
  - On misaligned_cond: no request is issued, misaligned pulses for one cycle, and the instruction retires with RegWrite=0.
- Stores: dmem_be = size mask << addr[2:0]; dmem_wdata = store_data << (8*addr[2:0]).
- Loads: the lane is selected by addr[2:0] and shifted to bit 0. funct3[2]=1 zero-extends (LBU, LHU, LWU); otherwise the value is sign-extended.
- FSM, RUN:
  - dmem_req = memop.
  - dmem_ready=1 in the same cycle is a zero-wait access with no stall.
  - dmem_req & !dmem_ready: stall=1, go to WAIT, clear the timeout counter.
- FSM, WAIT:
  - dmem_req stays high; addr, we, wdata and be are stable.
  - stall = !dmem_ready.
  - dmem_ready: return to RUN; the result is captured at that edge.
  - Timeout counter reaches TIMEOUT: set bus_error, drop dmem_req, retire with load data 0, return to RUN.
- stall = dmem_req & !dmem_ready, and is forced to 0 on the timeout cycle.
- MEM/WB capture:
  - stall=1: MEM/WB loads a bubble (RegWrite=0, Instruction=0).
  - Otherwise MEM/WB loads Instruction, RegWrite & valid, and WriteBack = mem_to_reg ? extended load data : ALU result.
- Counter: stall_cycles increments every cycle stall=1 and saturates at all-ones.
- Reset mid-access: dmem_req drops immediately and the FSM returns to RUN. The external memory must tolerate an abandoned request.
- Simultaneous branch and memop: not possible in the same instruction. A branch in EX/MEM with a stall pending in WAIT cannot occur because the branch entry follows the memop.

Decomposition:
- Shared package core_pkg:
  - funct3 size encodings.
  - FSM state constants RUN=0 and WAIT=1.
  - XLEN=64.
- Sub-module load_align (combinational): takes rdata, addr[2:0] and funct3 and returns the extended load value. It is reused by the stage's own store lane logic tests.

Test Plan:
- LD at 0x100, dmem_ready high on the first request cycle -> stall never asserted; one cycle later MEM_WB_WriteBack = dmem_rdata and MEM_WB_RegWrite=1.
- LB at 0x103 with rdata 0x00000000_80000000, 3-cycle ready delay -> stall high for 3 cycles, stall_cycles=3, WriteBack = 0xFFFFFFFFFFFFFF80. LBU at the same address -> 0x80.
- SH at 0x106 with store_data 0xBEEF -> dmem_be=0xC0, dmem_wdata=0xBEEF000000000000, dmem_we=1, MEM_WB_RegWrite=0.
- BEQ with Zero=1 and Target=0x2000 -> pc_src=flush=1 and branch_target=0x2000 for one cycle; next EX/MEM entry is a bubble (EX_MEM_RegWrite=0).
- LW at 0x102 -> no dmem_req, misaligned pulses once, MEM_WB_RegWrite=0.
- dmem_ready never asserted -> stall releases after TIMEOUT cycles, bus_error=1 and stays 1; reset clears it and all outputs are 0 asynchronously.
